// File: rtl/regfile_pkg.sv
// Shared constants and types for the CPU register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux with reg0 forced to zero.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
`ifdef REGFILE_BYPASS_EN
  input  logic              fwd_en,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic [DATA_W-1:0] fwd_data,
`endif
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // fwd_en already excludes reset and writes to reg0
    if (fwd_en && (fwd_addr == addr)) begin
      data = fwd_data;
    end
`endif
    if (addr == ADDR_W'(ZERO_REG)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: two combinational read ports, one synchronous write port.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWre,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;

  assign wr_ok = RegWre && (WriteReg != ADDR_W'(ZERO_REG));

  // Reset beats write; reg0 is never written so it stays at its reset value
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[WriteReg] <= WriteData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_en;
  assign fwd_en = wr_ok && !RST;
`endif

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs     (regs),
    .addr     (ReadReg1),
`ifdef REGFILE_BYPASS_EN
    .fwd_en   (fwd_en),
    .fwd_addr (WriteReg),
    .fwd_data (WriteData),
`endif
    .data     (ReadData1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs     (regs),
    .addr     (ReadReg2),
`ifdef REGFILE_BYPASS_EN
    .fwd_en   (fwd_en),
    .fwd_addr (WriteReg),
    .fwd_data (WriteData),
`endif
    .data     (ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized checks of register_file against an array model.
module tb_register_file;
  import regfile_pkg::*;

  logic              CLK = 1'b0;
  logic              RST;
  logic              RegWre;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  word_t model [NUM_REGS];
  int    checks = 0;
  int    errors = 0;

  register_file dut (
    .CLK       (CLK),
    .RST       (RST),
    .RegWre    (RegWre),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  always #5 CLK = ~CLK;

  // Expected read value for the current inputs and stored state
  function automatic word_t exp_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWre && !RST && WriteReg != 0 && WriteReg == a) return WriteData;
`endif
    return model[a];
  endfunction

  // Apply one rising edge to the model, then to the DUT
  task automatic tick();
    if (RST) begin
      for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
    end else if (RegWre && WriteReg != 0) begin
      model[WriteReg] = WriteData;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    #1;
    check_val({tag, "_rd1"}, ReadData1, exp_read(ReadReg1));
    check_val({tag, "_rd2"}, ReadData2, exp_read(ReadReg2));
  endtask

  initial begin
    RST = 1'b1; RegWre = 1'b0; ReadReg1 = '0; ReadReg2 = '0;
    WriteReg = '0; WriteData = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) model[i] = 32'hA5A5_A5A5;
    tick();

    // Reset state
    RST = 1'b0; ReadReg1 = 5'd1; ReadReg2 = 5'd31; #1;
    check_val("rst_r1", ReadData1, 32'd0);
    check_val("rst_r31", ReadData2, 32'd0);

    // Sequential writes
    RegWre = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      WriteReg = ADDR_W'(i); WriteData = DATA_W'(i);
      tick();
    end
    RegWre = 1'b0; ReadReg1 = 5'd1; ReadReg2 = 5'd2; #1;
    check_val("seq_r1", ReadData1, 32'd1);
    check_val("seq_r2", ReadData2, 32'd2);
    ReadReg1 = 5'd3; #1;
    check_val("seq_r3", ReadData1, 32'd3);

    // Write disabled
    RegWre = 1'b0; WriteReg = 5'd1; WriteData = 32'hDEAD_BEEF;
    tick();
    ReadReg1 = 5'd1; #1;
    check_val("wr_dis_r1", ReadData1, 32'd1);

    // Zero register ignores writes
    RegWre = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
    tick();
    RegWre = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0; #1;
    check_val("zero_rd1", ReadData1, 32'd0);
    check_val("zero_rd2", ReadData2, 32'd0);

    // Read-during-write
    RegWre = 1'b1; WriteReg = 5'd5; WriteData = 32'd7;
    tick();
    WriteData = 32'd9; ReadReg1 = 5'd5; ReadReg2 = 5'd5; #1;
`ifdef REGFILE_BYPASS_EN
    check_val("rdw_before", ReadData1, 32'd9);
`else
    check_val("rdw_before", ReadData1, 32'd7);
`endif
    check_val("rdw_same_addr", ReadData2, ReadData1);
    tick();
    RegWre = 1'b0; #1;
    check_val("rdw_after", ReadData1, 32'd9);

    // Reset beats a same-cycle write
    RST = 1'b1; RegWre = 1'b1; WriteReg = 5'd3; WriteData = 32'd3;
    ReadReg1 = 5'd1; ReadReg2 = 5'd3;
    tick();
    RST = 1'b0; RegWre = 1'b0; #1;
    check_val("rst_pri_r1", ReadData1, 32'd0);
    check_val("rst_pri_r3", ReadData2, 32'd0);
    ReadReg1 = 5'd2; ReadReg2 = 5'd5; #1;
    check_val("rst_pri_r2", ReadData1, 32'd0);
    check_val("rst_pri_r5", ReadData2, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      RST       = ($urandom_range(0, 39) == 0);
      RegWre    = ($urandom_range(0, 3) != 0);
      WriteReg  = ADDR_W'($urandom);
      WriteData = DATA_W'($urandom);
      ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : ADDR_W'($urandom);
      ReadReg2  = ($urandom_range(0, 7) == 0) ? ReadReg1 : ADDR_W'($urandom);
      check_model("rand");
      tick();
    end

    // Sweep every register after the random phase
    RST = 1'b0; RegWre = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      ReadReg1 = ADDR_W'(i);
      ReadReg2 = ADDR_W'(NUM_REGS - 1 - i);
      check_model("sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
